// File: rtl/mf_pll_supervisor.sv
// mf_pll_supervisor
// PLL bring-up and lock supervisor running on the free-running reference clock.
// It pulses the PLL reset, waits for lock with a timeout, and debounces lock
// before it releases the downstream system reset. It also detects loss of lock
// and keeps saturating counters of lock timeouts and lock losses.
//
// Optional build macro: MF_PLL_SUP_AUTO_RETRY_EN
//   defined   : a lock timeout or a loss of lock restarts the sequence from RESET.
//               FAIL is never entered and fail is tied low.
//   undefined : a lock timeout or a loss of lock enters FAIL. FAIL is left only
//               through rst.
//
// Ports
//   refclk     in   reference clock, the only clock
//   rst        in   asynchronous active-high reset
//   pll_locked in   PLL lock indication, asynchronous to refclk
//   pll_rst    out  PLL reset, high in RESET and FAIL
//   sys_rst    out  system reset, high in every state except RUN
//   ready      out  high only in RUN
//   fail       out  sticky failure flag, high only in FAIL
//   state      out  state encoding: RESET=0 WAIT=1 STABLE=2 RUN=3 FAIL=4
//   retry_cnt  out  saturating count of lock timeouts
//   loss_cnt   out  saturating count of lock losses seen in RUN
module mf_pll_supervisor #(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 64,
  parameter int CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic             fail,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  localparam int MAX_RS = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_T  = (MAX_RS > STABLE_CYCLES) ? MAX_RS : STABLE_CYCLES;
  // The timer only has to reach MAX_T-1.
  localparam int TMR_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);

`ifdef MF_PLL_SUP_AUTO_RETRY_EN
  localparam state_t ERR_NEXT = ST_RESET;
`else
  localparam state_t ERR_NEXT = ST_FAIL;
`endif

  // Counters hold at all-ones and never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  state_t           st;
  logic [TMR_W-1:0] timer;
  logic             sync_p0;
  logic             sync_p1;
  logic             locked_s;

  assign locked_s = sync_p1;

  // Stage p0/p1: two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pll_locked;
      sync_p1 <= sync_p0;
    end
  end

  // Supervisor state machine, all decisions on the synchronised lock.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      st        <= ST_RESET;
      timer     <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      case (st)
        ST_RESET: begin
          if (timer == RST_LAST) begin
            st    <= ST_WAIT;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_WAIT: begin
          if (locked_s) begin
            st    <= ST_STABLE;
            timer <= '0;
          end else if (timer == LOCK_LAST) begin
            st        <= ERR_NEXT;
            timer     <= '0;
            retry_cnt <= sat_inc(retry_cnt);
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_STABLE: begin
          // Any dropout restarts the full lock timeout, not the remaining part.
          if (!locked_s) begin
            st    <= ST_WAIT;
            timer <= '0;
          end else if (timer == STABLE_LAST) begin
            st    <= ST_RUN;
            timer <= '0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            st       <= ERR_NEXT;
            timer    <= '0;
            loss_cnt <= sat_inc(loss_cnt);
          end
        end
        ST_FAIL: begin
          st <= ST_FAIL;
        end
        default: begin
          st    <= ST_RESET;
          timer <= '0;
        end
      endcase
    end
  end

  // Moore decode of the registered state, so an asynchronous rst shows
  // on the outputs at once.
  assign state   = st;
  assign pll_rst = (st == ST_RESET) || (st == ST_FAIL);
  assign sys_rst = (st != ST_RUN);
  assign ready   = (st == ST_RUN);
`ifdef MF_PLL_SUP_AUTO_RETRY_EN
  assign fail    = 1'b0;
`else
  assign fail    = (st == ST_FAIL);
`endif

endmodule
